// File: rtl/jtag_l2_bridge_pkg.sv
// Shared types and constants for the JTAG-to-L2 burst bridge.
package jtag_l2_bridge_pkg;

   localparam int BEAT_BYTES = 4;
   localparam int MAX_BEATS  = 256;
   localparam int CMD_ADDR_W = 32;
   localparam int CMD_LEN_W  = $clog2(MAX_BEATS) + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2,
      DRAIN = 2'd3
   } bridge_state_e;

   typedef struct packed {
      logic                  we;
      logic [CMD_ADDR_W-1:0] addr;
      logic [CMD_LEN_W-1:0]  len;
   } cmd_t;

endpackage

// File: rtl/jtag_l2_rdbuf.sv
// Read-data buffer: small synchronous FIFO between L2 responses and the debug unit.
// A push into a full buffer is accepted when a pop happens in the same cycle.
module jtag_l2_rdbuf #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CNT_W-1:0] count_o
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   assign full_o  = (count_o == CNT_W'(DEPTH));
   assign empty_o = (count_o == '0);
   assign data_o  = mem[rd_ptr];

   // Storage, pointers and occupancy; storage is cleared so the head reads 0 after reset.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_o <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= data_i;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_o <= count_o + CNT_W'(1);
            2'b01:   count_o <= count_o - CNT_W'(1);
            default: count_o <= count_o;
         endcase
      end
   end

endmodule

// File: rtl/jtag_l2_bridge.sv
// JTAG debug burst commands -> single-beat L2 request/grant transactions.
// Optional range check against the L2 size: define JTAG_L2_BRIDGE_BOUNDS_CHECK_EN.
//
// state | meaning
// IDLE  | accepting a command; illegal commands pulse err_o
// WRITE | accepting write beats, one L2 write request per beat
// READ  | issuing L2 reads while buffer credit is available
// DRAIN | all reads granted; waiting for responses and buffer to empty
module jtag_l2_bridge
   import jtag_l2_bridge_pkg::*;
#(
   parameter int                    ADDR_WIDTH    = CMD_ADDR_W,
   parameter int                    DATA_WIDTH    = 8 * BEAT_BYTES,
   parameter int                    LEN_WIDTH     = CMD_LEN_W,
   parameter int                    RDBUF_DEPTH   = 4,
   parameter logic [ADDR_WIDTH-1:0] L2_SIZE_BYTES = 32'h0008_0000
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  cmd_valid_i,
   output logic                  cmd_ready_o,
   input  logic                  cmd_we_i,
   input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
   input  logic [LEN_WIDTH-1:0]  cmd_len_i,
   input  logic                  wdata_valid_i,
   output logic                  wdata_ready_o,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   output logic                  rdata_valid_o,
   input  logic                  rdata_ready_i,
   output logic [DATA_WIDTH-1:0] rdata_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  err_o,
   output logic                  mem_req_o,
   input  logic                  mem_gnt_i,
   output logic                  mem_we_o,
   output logic [3:0]            mem_be_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [DATA_WIDTH-1:0] mem_wdata_o,
   input  logic                  mem_rvalid_i,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

`ifdef JTAG_L2_BRIDGE_BOUNDS_CHECK_EN
   localparam bit BOUNDS_EN = 1'b1;
`else
   localparam bit BOUNDS_EN = 1'b0;
`endif

   localparam int CNT_W = $clog2(RDBUF_DEPTH) + 1;
   localparam int OCC_W = CNT_W + 1;

   bridge_state_e        state;
   cmd_t                 cmd_in;
   logic [LEN_WIDTH-1:0] beats_left;
   logic [LEN_WIDTH-1:0] beats_left_nxt;
   logic [LEN_WIDTH-1:0] accept_left;
   logic [CNT_W-1:0]     inflight;
   logic [CNT_W-1:0]     inflight_nxt;
   logic [CNT_W-1:0]     buf_count;
   logic [CNT_W-1:0]     cnt_nxt;
   logic [OCC_W-1:0]     occ_nxt;
   logic                 credit_ok;
   logic                 buf_full;
   logic                 buf_empty;
   logic                 cmd_fire;
   logic                 cmd_bad;
   logic                 out_of_range;
   logic [ADDR_WIDTH:0]  span_end;
   logic                 wr_fire;
   logic                 gnt_fire;
   logic                 rd_gnt;
   logic                 rd_push;
   logic                 rd_pop;

   assign cmd_in = '{we: cmd_we_i, addr: cmd_addr_i, len: cmd_len_i};

   // End of the byte range touched by the command, one bit wider than the address.
   assign span_end     = {1'b0, cmd_in.addr}
                       + {{(ADDR_WIDTH - LEN_WIDTH - 1){1'b0}}, cmd_in.len, 2'b00};
   assign out_of_range = (span_end > {1'b0, L2_SIZE_BYTES});
   assign cmd_bad      = (cmd_in.addr[1:0] != 2'b00) || (cmd_in.len == '0)
                       || (BOUNDS_EN && out_of_range);

   assign cmd_fire      = cmd_valid_i && cmd_ready_o;
   assign wdata_ready_o = (state == WRITE) && (accept_left != '0) && (!mem_req_o || mem_gnt_i);
   assign wr_fire       = wdata_valid_i && wdata_ready_o;
   assign gnt_fire      = mem_req_o && mem_gnt_i;
   assign rd_gnt        = gnt_fire && (state == READ);
   assign rd_pop        = rdata_valid_o && rdata_ready_i;
   // A response with nothing in flight is stale (e.g. issued before a reset) and is dropped.
   assign rd_push       = mem_rvalid_i && (inflight != '0) && (!buf_full || rd_pop);

   assign rdata_valid_o = !buf_empty;
   assign busy_o        = (state != IDLE);
   assign mem_be_o      = 4'hF;

   // Next-cycle occupancy (in flight + buffered) decides whether another read may issue.
   always_comb begin
      inflight_nxt = inflight;
      if (rd_gnt)  inflight_nxt = inflight_nxt + CNT_W'(1);
      if (rd_push) inflight_nxt = inflight_nxt - CNT_W'(1);
      cnt_nxt = buf_count;
      if (rd_push) cnt_nxt = cnt_nxt + CNT_W'(1);
      if (rd_pop)  cnt_nxt = cnt_nxt - CNT_W'(1);
      occ_nxt        = {1'b0, inflight_nxt} + {1'b0, cnt_nxt};
      credit_ok      = (occ_nxt < OCC_W'(RDBUF_DEPTH));
      beats_left_nxt = gnt_fire ? (beats_left - LEN_WIDTH'(1)) : beats_left;
   end

   jtag_l2_rdbuf #(
      .DEPTH (RDBUF_DEPTH),
      .WIDTH (DATA_WIDTH),
      .CNT_W (CNT_W)
   ) u_rdbuf (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (rd_push),
      .data_i  (mem_rdata_i),
      .pop_i   (rd_pop),
      .data_o  (rdata_o),
      .full_o  (buf_full),
      .empty_o (buf_empty),
      .count_o (buf_count)
   );

   // Control FSM with registered L2 request and status outputs.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state       <= IDLE;
         cmd_ready_o <= 1'b0;
         done_o      <= 1'b0;
         err_o       <= 1'b0;
         mem_req_o   <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= '0;
         mem_wdata_o <= '0;
         beats_left  <= '0;
         accept_left <= '0;
         inflight    <= '0;
      end else begin
         done_o   <= 1'b0;
         err_o    <= 1'b0;
         inflight <= inflight_nxt;
         unique case (state)
            IDLE: begin
               cmd_ready_o <= 1'b1;
               if (cmd_fire) begin
                  if (cmd_bad) begin
                     err_o <= 1'b1;
                  end else begin
                     cmd_ready_o <= 1'b0;
                     mem_addr_o  <= cmd_in.addr;
                     beats_left  <= cmd_in.len;
                     accept_left <= cmd_in.len;
                     if (cmd_in.we) begin
                        state <= WRITE;
                     end else begin
                        // Buffer is empty and nothing is in flight, so the first read can go out now.
                        state     <= READ;
                        mem_req_o <= 1'b1;
                        mem_we_o  <= 1'b0;
                     end
                  end
               end
            end
            WRITE: begin
               beats_left <= beats_left_nxt;
               if (gnt_fire) begin
                  mem_addr_o <= mem_addr_o + ADDR_WIDTH'(BEAT_BYTES);
               end
               if (wr_fire) begin
                  mem_req_o   <= 1'b1;
                  mem_we_o    <= 1'b1;
                  mem_wdata_o <= wdata_i;
                  accept_left <= accept_left - LEN_WIDTH'(1);
               end else if (gnt_fire) begin
                  mem_req_o <= 1'b0;
                  mem_we_o  <= 1'b0;
               end
               if (gnt_fire && (beats_left_nxt == '0)) begin
                  done_o      <= 1'b1;
                  cmd_ready_o <= 1'b1;
                  state       <= IDLE;
               end
            end
            READ: begin
               beats_left <= beats_left_nxt;
               if (gnt_fire) begin
                  mem_addr_o <= mem_addr_o + ADDR_WIDTH'(BEAT_BYTES);
               end
               if (beats_left_nxt == '0) begin
                  mem_req_o <= 1'b0;
                  state     <= DRAIN;
               end else begin
                  mem_req_o <= (mem_req_o && !mem_gnt_i) || credit_ok;
               end
            end
            DRAIN: begin
               if ((inflight == '0) && buf_empty) begin
                  done_o      <= 1'b1;
                  cmd_ready_o <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_jtag_l2_bridge.sv
// Directed bench for jtag_l2_bridge with an L2 responder model (1-cycle read latency).
module tb_jtag_l2_bridge;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        cmd_valid_i = 1'b0;
   logic        cmd_ready_o;
   logic        cmd_we_i = 1'b0;
   logic [31:0] cmd_addr_i = '0;
   logic [8:0]  cmd_len_i = '0;
   logic        wdata_valid_i = 1'b0;
   logic        wdata_ready_o;
   logic [31:0] wdata_i = '0;
   logic        rdata_valid_o;
   logic        rdata_ready_i = 1'b0;
   logic [31:0] rdata_o;
   logic        busy_o;
   logic        done_o;
   logic        err_o;
   logic        mem_req_o;
   logic        mem_gnt_i = 1'b0;
   logic        mem_we_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic        mem_rvalid_i = 1'b0;
   logic [31:0] mem_rdata_i = '0;

   int n_cmp = 0;
   int n_bad = 0;

   int gnt_mode = 0;
   int gnt_ctr  = 0;

   int          n_grant = 0;
   int          n_done = 0;
   int          n_err = 0;
   int          n_req_cyc = 0;
   int          n_stable_viol = 0;
   logic [31:0] g_addr [$];
   logic        g_we [$];
   logic [31:0] g_data [$];
   logic [31:0] rd_log [$];
   logic [31:0] mem_model [logic [31:0]];
   bit          rsp_pend = 0;
   logic [31:0] rsp_data = '0;
   bit          prev_hold = 0;
   logic [31:0] hold_addr = '0;
   logic [31:0] hold_data = '0;
   logic        hold_we = 1'b0;

   jtag_l2_bridge dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .cmd_valid_i   (cmd_valid_i),
      .cmd_ready_o   (cmd_ready_o),
      .cmd_we_i      (cmd_we_i),
      .cmd_addr_i    (cmd_addr_i),
      .cmd_len_i     (cmd_len_i),
      .wdata_valid_i (wdata_valid_i),
      .wdata_ready_o (wdata_ready_o),
      .wdata_i       (wdata_i),
      .rdata_valid_o (rdata_valid_o),
      .rdata_ready_i (rdata_ready_i),
      .rdata_o       (rdata_o),
      .busy_o        (busy_o),
      .done_o        (done_o),
      .err_o         (err_o),
      .mem_req_o     (mem_req_o),
      .mem_gnt_i     (mem_gnt_i),
      .mem_we_o      (mem_we_o),
      .mem_be_o      (mem_be_o),
      .mem_addr_o    (mem_addr_o),
      .mem_wdata_o   (mem_wdata_o),
      .mem_rvalid_i  (mem_rvalid_i),
      .mem_rdata_i   (mem_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   // L2 side drive: grant pattern and read response, changed just after the rising edge.
   always @(posedge clk_i) begin
      #1;
      gnt_ctr = gnt_ctr + 1;
      case (gnt_mode)
         0:       mem_gnt_i = 1'b1;
         1:       mem_gnt_i = ((gnt_ctr % 4) == 0);
         default: mem_gnt_i = 1'b0;
      endcase
      mem_rvalid_i = rsp_pend;
      mem_rdata_i  = rsp_pend ? rsp_data : 32'h0;
   end

   // Mid-cycle monitor: logs grants, pops and pulses, updates the memory model.
   always @(negedge clk_i) begin
      if (rst_i) begin
         prev_hold = 0;
         rsp_pend  = 0;
      end else begin
         if (prev_hold) begin
            if (!mem_req_o || mem_addr_o !== hold_addr || mem_we_o !== hold_we
                || (hold_we && mem_wdata_o !== hold_data))
               n_stable_viol = n_stable_viol + 1;
         end
         rsp_pend = 0;
         if (mem_req_o) n_req_cyc = n_req_cyc + 1;
         if (mem_req_o && mem_gnt_i) begin
            n_grant = n_grant + 1;
            g_addr.push_back(mem_addr_o);
            g_we.push_back(mem_we_o);
            g_data.push_back(mem_wdata_o);
            if (mem_we_o) begin
               mem_model[mem_addr_o] = mem_wdata_o;
            end else begin
               rsp_pend = 1;
               rsp_data = mem_model.exists(mem_addr_o) ? mem_model[mem_addr_o]
                                                       : (mem_addr_o ^ 32'h5A5A_0000);
            end
         end
         prev_hold = mem_req_o && !mem_gnt_i;
         hold_addr = mem_addr_o;
         hold_data = mem_wdata_o;
         hold_we   = mem_we_o;
         if (done_o) n_done = n_done + 1;
         if (err_o)  n_err  = n_err + 1;
         if (rdata_valid_o && rdata_ready_i) rd_log.push_back(rdata_o);
      end
   end

   task automatic issue_cmd(input logic we, input logic [31:0] addr, input logic [8:0] len,
                            output bit ok);
      bit hs;
      ok = 0;
      cmd_valid_i = 1'b1;
      cmd_we_i    = we;
      cmd_addr_i  = addr;
      cmd_len_i   = len;
      for (int t = 0; t < 40 && !ok; t++) begin
         @(negedge clk_i);
         hs = cmd_ready_o;
         @(posedge clk_i);
         #2;
         if (hs) ok = 1;
      end
      cmd_valid_i = 1'b0;
   endtask

   task automatic send_beat(input logic [31:0] data, output bit ok);
      bit hs;
      ok = 0;
      wdata_valid_i = 1'b1;
      wdata_i       = data;
      for (int t = 0; t < 40 && !ok; t++) begin
         @(negedge clk_i);
         hs = wdata_ready_o;
         @(posedge clk_i);
         #2;
         if (hs) ok = 1;
      end
      wdata_valid_i = 1'b0;
   endtask

   task automatic wait_done(input int base, input int limit, output bit ok);
      ok = 0;
      for (int t = 0; t < limit && !ok; t++) begin
         if (n_done > base) ok = 1;
         else begin
            @(posedge clk_i);
            #2;
         end
      end
   endtask

   task automatic test_reset;
      repeat (2) @(posedge clk_i);
      #2;
      n_cmp++;
      if ({cmd_ready_o, wdata_ready_o, rdata_valid_o, busy_o, done_o, err_o,
           mem_req_o, mem_we_o, mem_be_o} !== 12'h00F) begin
         n_bad++;
         $display("FAIL reset_ctrl: got %h want 00f", {cmd_ready_o, wdata_ready_o, rdata_valid_o,
                  busy_o, done_o, err_o, mem_req_o, mem_we_o, mem_be_o});
      end
      n_cmp++;
      if ({mem_addr_o, mem_wdata_o, rdata_o} !== 96'h0) begin
         n_bad++;
         $display("FAIL reset_data: addr %h wdata %h rdata %h want 0", mem_addr_o, mem_wdata_o, rdata_o);
      end
      rst_i = 1'b0;
      repeat (2) @(posedge clk_i);
      #2;
      n_cmp++;
      if (cmd_ready_o !== 1'b1 || busy_o !== 1'b0) begin
         n_bad++;
         $display("FAIL idle_ready: cmd_ready %b busy %b want 1 0", cmd_ready_o, busy_o);
      end
   endtask

   task automatic test_single_write;
      bit ok;
      int g0 = n_grant, d0 = n_done, e0 = n_err;
      gnt_mode = 0;
      issue_cmd(1'b1, 32'h0, 9'd1, ok);
      send_beat(32'hABBAABBA, ok);
      n_cmp++;
      if (!ok) begin n_bad++; $display("FAIL wr1_accept: beat not accepted, want accepted"); end
      @(negedge clk_i);
      n_cmp++;
      if ({mem_req_o, mem_we_o} !== 2'b11 || mem_addr_o !== 32'h0 || mem_wdata_o !== 32'hABBAABBA) begin
         n_bad++;
         $display("FAIL wr1_req: req %b we %b addr %h data %h want 1 1 0 abbaabba",
                  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o);
      end
      @(negedge clk_i);
      n_cmp++;
      if (mem_req_o !== 1'b0 || done_o !== 1'b1) begin
         n_bad++;
         $display("FAIL wr1_latency: req %b done %b want 0 1", mem_req_o, done_o);
      end
      repeat (3) @(posedge clk_i);
      #2;
      n_cmp++;
      if (n_grant - g0 != 1 || n_done - d0 != 1 || n_err - e0 != 0) begin
         n_bad++;
         $display("FAIL wr1_counts: grants %0d done %0d err %0d want 1 1 0",
                  n_grant - g0, n_done - d0, n_err - e0);
      end
   endtask

   task automatic test_single_read;
      bit ok;
      int g0 = n_grant, d0 = n_done;
      gnt_mode = 0;
      rdata_ready_i = 1'b1;
      issue_cmd(1'b0, 32'h0, 9'd1, ok);
      @(negedge clk_i);
      n_cmp++;
      if (mem_req_o !== 1'b1 || mem_we_o !== 1'b0 || mem_addr_o !== 32'h0) begin
         n_bad++;
         $display("FAIL rd1_req: req %b we %b addr %h want 1 0 0", mem_req_o, mem_we_o, mem_addr_o);
      end
      @(negedge clk_i);
      n_cmp++;
      if (rdata_valid_o !== 1'b0) begin
         n_bad++;
         $display("FAIL rd1_early: rdata_valid %b want 0", rdata_valid_o);
      end
      @(negedge clk_i);
      n_cmp++;
      if (rdata_valid_o !== 1'b1 || rdata_o !== 32'hABBAABBA) begin
         n_bad++;
         $display("FAIL rd1_data: valid %b data %h want 1 abbaabba", rdata_valid_o, rdata_o);
      end
      wait_done(d0, 20, ok);
      n_cmp++;
      if (!ok || n_grant - g0 != 1) begin
         n_bad++;
         $display("FAIL rd1_done: done_seen %0d grants %0d want 1 1", ok, n_grant - g0);
      end
   endtask

   task automatic test_write_backpressure;
      bit ok;
      bit all_ok = 1;
      int g0 = n_grant, d0 = n_done, s0 = n_stable_viol;
      int bad_addr = 0;
      gnt_mode = 1;
      issue_cmd(1'b1, 32'h100, 9'd256, ok);
      for (int i = 0; i < 256; i++) begin
         send_beat(32'hC0DE0000 | i, ok);
         if (!ok) all_ok = 0;
      end
      wait_done(d0, 40, ok);
      repeat (3) @(posedge clk_i);
      #2;
      n_cmp++;
      if (!all_ok || !ok) begin
         n_bad++;
         $display("FAIL wr256_flow: beats_ok %0d done_seen %0d want 1 1", all_ok, ok);
      end
      n_cmp++;
      if (n_grant - g0 != 256 || n_done - d0 != 1) begin
         n_bad++;
         $display("FAIL wr256_counts: grants %0d done %0d want 256 1", n_grant - g0, n_done - d0);
      end
      if (n_grant - g0 == 256) begin
         for (int i = 0; i < 256; i++) begin
            if (g_addr[g0 + i] !== 32'h100 + 4 * i || g_data[g0 + i] !== (32'hC0DE0000 | i)
                || g_we[g0 + i] !== 1'b1)
               bad_addr++;
         end
      end
      n_cmp++;
      if (bad_addr != 0) begin
         n_bad++;
         $display("FAIL wr256_order: %0d beats with wrong addr/data, want 0", bad_addr);
      end
      n_cmp++;
      if (n_stable_viol - s0 != 0) begin
         n_bad++;
         $display("FAIL wr256_hold: %0d unstable ungranted requests, want 0", n_stable_viol - s0);
      end
      gnt_mode = 0;
   endtask

   task automatic test_read_credit;
      bit ok;
      int g0 = n_grant, d0 = n_done, r0 = rd_log.size();
      int bad = 0;
      gnt_mode = 0;
      rdata_ready_i = 1'b0;
      issue_cmd(1'b0, 32'h100, 9'd16, ok);
      repeat (20) @(posedge clk_i);
      #2;
      n_cmp++;
      if (n_grant - g0 != 4 || mem_req_o !== 1'b0 || rdata_valid_o !== 1'b1) begin
         n_bad++;
         $display("FAIL rd16_credit: grants %0d req %b valid %b want 4 0 1",
                  n_grant - g0, mem_req_o, rdata_valid_o);
      end
      rdata_ready_i = 1'b1;
      wait_done(d0, 100, ok);
      n_cmp++;
      if (!ok || n_grant - g0 != 16 || rd_log.size() - r0 != 16) begin
         n_bad++;
         $display("FAIL rd16_counts: done_seen %0d grants %0d beats %0d want 1 16 16",
                  ok, n_grant - g0, rd_log.size() - r0);
      end
      if (rd_log.size() - r0 == 16) begin
         for (int i = 0; i < 16; i++)
            if (rd_log[r0 + i] !== (32'hC0DE0000 | i)) bad++;
      end
      n_cmp++;
      if (bad != 0) begin
         n_bad++;
         $display("FAIL rd16_data: %0d beats out of order or wrong, want 0", bad);
      end
   endtask

   task automatic test_illegal;
      bit ok;
      int g0, e0, q0;
      g0 = n_grant; e0 = n_err; q0 = n_req_cyc;
      issue_cmd(1'b0, 32'h2, 9'd1, ok);
      n_cmp++;
      if (err_o !== 1'b1 || busy_o !== 1'b0) begin
         n_bad++;
         $display("FAIL bad_align_err: err %b busy %b want 1 0", err_o, busy_o);
      end
      repeat (3) @(posedge clk_i);
      #2;
      n_cmp++;
      if (n_err - e0 != 1 || n_req_cyc - q0 != 0 || cmd_ready_o !== 1'b1) begin
         n_bad++;
         $display("FAIL bad_align_after: errs %0d req_cycles %0d ready %b want 1 0 1",
                  n_err - e0, n_req_cyc - q0, cmd_ready_o);
      end
      e0 = n_err; q0 = n_req_cyc;
      issue_cmd(1'b1, 32'h40, 9'd0, ok);
      n_cmp++;
      if (err_o !== 1'b1 || wdata_ready_o !== 1'b0) begin
         n_bad++;
         $display("FAIL bad_len_err: err %b wdata_ready %b want 1 0", err_o, wdata_ready_o);
      end
      repeat (3) @(posedge clk_i);
      #2;
      n_cmp++;
      if (n_err - e0 != 1 || n_grant - g0 != 0 || n_req_cyc - q0 != 0
          || cmd_ready_o !== 1'b1 || busy_o !== 1'b0) begin
         n_bad++;
         $display("FAIL bad_len_after: errs %0d grants %0d ready %b busy %b want 1 0 1 0",
                  n_err - e0, n_grant - g0, cmd_ready_o, busy_o);
      end
   endtask

   task automatic test_reset_mid_read;
      bit ok;
      bit seen = 0;
      int g0 = n_grant, d0, r0;
      gnt_mode = 0;
      rdata_ready_i = 1'b1;
      issue_cmd(1'b0, 32'h100, 9'd8, ok);
      for (int t = 0; t < 20 && !seen; t++) begin
         @(negedge clk_i);
         #1;
         if (n_grant - g0 >= 3) seen = 1;
      end
      n_cmp++;
      if (!seen) begin n_bad++; $display("FAIL rst_mid_wait: 3 grants not seen, want seen"); end
      rst_i = 1'b1;
      #1;
      n_cmp++;
      if ({cmd_ready_o, wdata_ready_o, rdata_valid_o, busy_o, done_o, err_o,
           mem_req_o, mem_we_o, mem_be_o} !== 12'h00F || mem_addr_o !== 32'h0 || rdata_o !== 32'h0) begin
         n_bad++;
         $display("FAIL rst_mid_outputs: ctrl %h addr %h rdata %h want 00f 0 0",
                  {cmd_ready_o, wdata_ready_o, rdata_valid_o, busy_o, done_o, err_o,
                   mem_req_o, mem_we_o, mem_be_o}, mem_addr_o, rdata_o);
      end
      @(posedge clk_i);
      #3;
      rst_i = 1'b0;
      g0 = n_grant; r0 = rd_log.size();
      repeat (4) @(posedge clk_i);
      #2;
      n_cmp++;
      if (rdata_valid_o !== 1'b0 || busy_o !== 1'b0 || cmd_ready_o !== 1'b1 || n_grant != g0) begin
         n_bad++;
         $display("FAIL rst_mid_stale: valid %b busy %b ready %b grants %0d want 0 0 1 0",
                  rdata_valid_o, busy_o, cmd_ready_o, n_grant - g0);
      end
      d0 = n_done;
      issue_cmd(1'b0, 32'h104, 9'd2, ok);
      wait_done(d0, 30, ok);
      n_cmp++;
      if (!ok || rd_log.size() - r0 != 2 || n_grant - g0 != 2) begin
         n_bad++;
         $display("FAIL rst_next_cmd: done_seen %0d beats %0d grants %0d want 1 2 2",
                  ok, rd_log.size() - r0, n_grant - g0);
      end else begin
         n_cmp++;
         if (rd_log[r0] !== 32'hC0DE0001 || rd_log[r0 + 1] !== 32'hC0DE0002) begin
            n_bad++;
            $display("FAIL rst_next_data: %h %h want c0de0001 c0de0002", rd_log[r0], rd_log[r0 + 1]);
         end
      end
   endtask

   task automatic test_bounds;
      bit ok;
      int g0 = n_grant, e0 = n_err, d0 = n_done;
      gnt_mode = 0;
      rdata_ready_i = 1'b1;
      issue_cmd(1'b0, 32'h0007_FFFC, 9'd2, ok);
`ifdef JTAG_L2_BRIDGE_BOUNDS_CHECK_EN
      repeat (4) @(posedge clk_i);
      #2;
      n_cmp++;
      if (n_err - e0 != 1 || n_grant - g0 != 0) begin
         n_bad++;
         $display("FAIL bounds_reject: errs %0d grants %0d want 1 0", n_err - e0, n_grant - g0);
      end
      e0 = n_err;
      issue_cmd(1'b1, 32'hFFFF_FFFC, 9'd2, ok);
      repeat (4) @(posedge clk_i);
      #2;
      n_cmp++;
      if (n_err - e0 != 1 || n_grant - g0 != 0 || busy_o !== 1'b0) begin
         n_bad++;
         $display("FAIL bounds_top: errs %0d grants %0d busy %b want 1 0 0",
                  n_err - e0, n_grant - g0, busy_o);
      end
`else
      wait_done(d0, 30, ok);
      n_cmp++;
      if (!ok || n_err != e0 || n_grant - g0 != 2) begin
         n_bad++;
         $display("FAIL nobounds_read: done_seen %0d errs %0d grants %0d want 1 0 2",
                  ok, n_err - e0, n_grant - g0);
      end else begin
         n_cmp++;
         if (g_addr[g0] !== 32'h0007_FFFC || g_addr[g0 + 1] !== 32'h0008_0000) begin
            n_bad++;
            $display("FAIL nobounds_addr: %h %h want 0007fffc 00080000", g_addr[g0], g_addr[g0 + 1]);
         end
      end
      g0 = n_grant; d0 = n_done;
      issue_cmd(1'b1, 32'hFFFF_FFFC, 9'd2, ok);
      send_beat(32'h1111_1111, ok);
      send_beat(32'h2222_2222, ok);
      wait_done(d0, 30, ok);
      n_cmp++;
      if (!ok || n_grant - g0 != 2) begin
         n_bad++;
         $display("FAIL wrap_write: done_seen %0d grants %0d want 1 2", ok, n_grant - g0);
      end else begin
         n_cmp++;
         if (g_addr[g0] !== 32'hFFFF_FFFC || g_addr[g0 + 1] !== 32'h0000_0000
             || g_data[g0 + 1] !== 32'h2222_2222) begin
            n_bad++;
            $display("FAIL wrap_addr: %h %h data %h want fffffffc 00000000 22222222",
                     g_addr[g0], g_addr[g0 + 1], g_data[g0 + 1]);
         end
      end
`endif
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_single_read();
      test_write_backpressure();
      test_read_credit();
      test_illegal();
      test_reset_mid_read();
      test_bounds();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/jtag_l2_bridge.md
Name: jtag_l2_bridge

Overview:
Converts 32-bit read/write burst commands from the JTAG debug unit into single-beat transactions on the L2 SRAM request/grant port. It sits directly downstream of the TAP/debug unit and upstream of the L2 memory in the jtagL2test subsystem. The commands arrive already synchronised into the system clock domain. It handles address incrementing, beat counting, grant back-pressure and read-data buffering, and flags illegal commands.

Parameters:
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 32, data word width; fixed at 32, other values unsupported
LEN_WIDTH, 9, width of the beat-count field; max burst is 256 beats
RDBUF_DEPTH, 4, read-data buffer entries and max reads in flight; power of 2, at least 2
L2_SIZE_BYTES, 32'h0008_0000, L2 size; used only by the optional feature

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous, active-high reset
cmd_valid_i  in  1  command valid
cmd_ready_o  out  1  command accepted when valid and ready are both high
cmd_we_i  in  1  1 = write burst, 0 = read burst
cmd_addr_i  in  ADDR_WIDTH  start byte address
cmd_len_i  in  LEN_WIDTH  beat count; legal range 1..256
wdata_valid_i  in  1  write beat valid
wdata_ready_o  out  1  write beat accepted
wdata_i  in  DATA_WIDTH  write beat data
rdata_valid_o  out  1  read beat valid
rdata_ready_i  in  1  read beat consumed
rdata_o  out  DATA_WIDTH  read beat data
busy_o  out  1  command in progress
done_o  out  1  one-cycle pulse when a burst completes
err_o  out  1  one-cycle pulse when a command is rejected
mem_req_o  out  1  L2 request
mem_gnt_i  in  1  L2 grant
mem_we_o  out  1  L2 write enable
mem_be_o  out  4  byte enables; always 4'hF
mem_addr_o  out  ADDR_WIDTH  L2 byte address
mem_wdata_o  out  DATA_WIDTH  L2 write data
mem_rvalid_i  in  1  L2 read data valid; arrives exactly 1 cycle after a read grant
mem_rdata_i  in  DATA_WIDTH  L2 read data

Behaviour:
- Reset values: all outputs are 0, except mem_be_o = 4'hF. FSM = IDLE. Read buffer empty. Counters = 0.
- States: IDLE, WRITE, READ, DRAIN.
- IDLE:
  - cmd_ready_o = 1.
  - On handshake, latch addr, len and we.
  - Reject the command if addr[1:0] != 0 or len == 0: pulse err_o the next cycle, stay in IDLE, issue no mem request.
  - Otherwise go to WRITE (we = 1) or READ (we = 0).
- WRITE:
  - wdata_ready_o = !mem_req_o || mem_gnt_i.
  - An accepted beat drives mem_req_o = 1, mem_we_o = 1, the current address and the data in the next cycle.
  - Hold req, addr and data stable until mem_gnt_i. On grant, addr += 4 and beats_left -= 1.
  - A new beat accepted in the grant cycle gives back-to-back requests, i.e. 1 beat per cycle peak.
  - After the last grant: mem_req_o = 0, pulse done_o, go to IDLE.
- READ:
  - Issue mem_req_o with mem_we_o = 0 while (inflight + buffered) < RDBUF_DEPTH.
  - On each grant, addr += 4.
  - Each mem_rvalid_i pushes mem_rdata_i into the buffer. The buffer cannot overflow because of the credit rule.
  - rdata_o and rdata_valid_o show the buffer head. Pop on rdata_valid_o && rdata_ready_i.
  - After the last grant, go to DRAIN.
- DRAIN: when inflight == 0 and the buffer is empty, pulse done_o and go to IDLE.
- busy_o = (state != IDLE).
- Address wrap: addr increments modulo 2^ADDR_WIDTH with no error.
- Simultaneous push and pop on the buffer: occupancy is unchanged, and a full buffer still accepts the push.
- Reset asserted mid-burst: all state clears on the same edge. The pending beat count is discarded and mem_req_o drops immediately. A read response returning after reset is ignored.
- Latency: a single write takes 2 cycles from the wdata handshake to mem_req_o deassert with zero-wait grant. A read takes 3 cycles from the cmd handshake to rdata_valid_o with zero-wait grant.

Optional Feature:
- Macro: JTAG_L2_BRIDGE_BOUNDS_CHECK_EN.
- Defined: a command is also rejected when addr + 4*len > L2_SIZE_BYTES, computed in ADDR_WIDTH+1 bits. The rejection pulses err_o and issues no request.
- Not defined: no range check, and the address wraps as above.

Decomposition:
- Package jtag_l2_bridge_pkg holds:
  - state enum bridge_state_e (IDLE, WRITE, READ, DRAIN)
  - typedef cmd_t {we, addr, len}
  - constants BEAT_BYTES = 4 and MAX_BEATS = 256
- Sub-module jtag_l2_rdbuf: synchronous FIFO, RDBUF_DEPTH entries, push/pop/full/empty/count, asynchronous active-high reset.

Test Plan:
- Write addr 0x0, len 1, data 32'hABBAABBA, zero-wait grant -> one mem_req_o with we = 1, addr 0x0, wdata 32'hABBAABBA; done_o pulses once; no err_o.
- Read addr 0x0, len 1 after that write -> one read request to 0x0; rdata_o = 32'hABBAABBA with rdata_valid_o; then done_o.
- Write 256 beats from 0x100 with mem_gnt_i low for 3 of every 4 cycles -> addresses 0x100..0x4FC in order, request held stable while ungranted, exactly 256 grants, done_o once.
- Read 16 beats with rdata_ready_i held low -> exactly 4 grants and then mem_req_o held low. Raising ready gives beats in order with no loss or duplication.
- cmd_addr_i = 0x2, and separately len = 0 -> err_o pulses, no mem_req_o, state returns to IDLE with cmd_ready_o = 1.
- Assert rst_i mid 8-beat read after 3 grants -> all outputs are at reset values the same cycle; the next command executes correctly.
- With the macro defined, addr 0x7FFFC, len 2 -> err_o pulses and no request. Without it, 2 requests go out and the second is at 0x80000.
